core_launch: RTL and testbench

Per-core launch and lifetime tracker that sits directly downstream of the fork stage. It consumes the per-core enable vector and fork contexts (valid, data pointer, start PC) the fork stage produces. It loads each newly forked context into the target core and issues a one-cycle start pulse. It tracks every core through to halt and feeds the registered enable vector back to the fork stage as its `core_ens_in`, so a core is never re-forked until it has fully drained.

---
 rtl/core_launch.sv | 120 ++++++++++++
 tb/tb_core_launch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/core_launch.sv
// Per-core launch/lifetime tracker downstream of the fork stage.
// Loads forked contexts, pulses start, tracks each core to halt.
module core_launch #(
  parameter int          NCORES  = 4,
  parameter logic [15:0] BOOT_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    core_ens_in,
  input  logic [NCORES*33-1:0] fork_cxt_in,
  input  logic [NCORES-1:0]    core_halt,
  output logic [NCORES-1:0]    core_ens_out,
  output logic [NCORES-1:0]    core_start,
  output logic [NCORES-1:0]    core_run,
  output logic [NCORES*16-1:0] core_pc,
  output logic [NCORES*16-1:0] core_ptr,
  output logic [4:0]           active_count,
  output logic                 all_idle,
  output logic                 fork_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_e;

  state_e st_q [NCORES];
  state_e st_d [NCORES];

  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    ens_q, ens_d;
  logic [NCORES-1:0]    start_q, start_d;
  logic [NCORES-1:0]    run_q, run_d;
  logic [NCORES*16-1:0] pc_q, pc_d;
  logic [NCORES*16-1:0] ptr_q, ptr_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 idle_q, idle_d;
  logic                 err_q, err_d;

  always_comb begin
    for (int i = 0; i < NCORES; i++) begin
      req[i] = core_ens_in[i] & fork_cxt_in[i*33+32];
    end
  end

  always_comb begin
    err_d = err_q;
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = '0;
    ens_d = '0;
    start_d = '0;
    run_d = '0;
    for (int i = 0; i < NCORES; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        IDLE: begin
          if (req[i]) begin
            st_d[i] = LOAD;
            pc_d[i*16 +: 16]  = fork_cxt_in[i*33 +: 16];
            ptr_d[i*16 +: 16] = fork_cxt_in[i*33+16 +: 16];
          end
        end
        LOAD: st_d[i] = RUN;
        RUN: begin
          if (core_halt[i]) st_d[i] = DRAIN;
        end
        DRAIN: st_d[i] = IDLE;
      endcase
      // a busy core never accepts a fork; flag it instead
      if (req[i] && st_q[i] != IDLE) err_d = 1'b1;
      ens_d[i]   = st_d[i] != IDLE;
      start_d[i] = st_d[i] == LOAD;
      run_d[i]   = st_d[i] == RUN;
      cnt_d      = cnt_d + 5'(ens_d[i]);
    end
    idle_d = cnt_d == 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCORES; i++) begin
        st_q[i] <= (i == 0) ? RUN : IDLE;
      end
      ens_q   <= NCORES'(1);
      run_q   <= NCORES'(1);
      start_q <= '0;
      pc_q    <= '0;
      pc_q[15:0] <= BOOT_PC;
      ptr_q   <= '0;
      cnt_q   <= 5'd1;
      idle_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        st_q[i] <= st_d[i];
      end
      ens_q   <= ens_d;
      run_q   <= run_d;
      start_q <= start_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  assign core_ens_out = ens_q;
  assign core_start   = start_q;
  assign core_run     = run_q;
  assign core_pc      = pc_q;
  assign core_ptr     = ptr_q;
  assign active_count = cnt_q;
  assign all_idle     = idle_q;
  assign fork_err     = err_q;

endmodule

// File: tb/tb_core_launch.sv
// Directed bench for core_launch: fork, halt/drain, refork,
// concurrent events, full drain and mid-operation reset.
module tb_core_launch;

  localparam int          N  = 4;
  localparam logic [15:0] BP = 16'hB000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   ens_in;
  logic [N*33-1:0] cxt;
  logic [N-1:0]   halt;
  logic [N-1:0]   ens_out, start, run;
  logic [N*16-1:0] pc, ptr;
  logic [4:0]     cnt;
  logic           idle, err;

  int checks = 0;
  int failures = 0;

  core_launch #(.NCORES(N), .BOOT_PC(BP)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_ens_in(ens_in), .fork_cxt_in(cxt),
    .core_halt(halt), .core_ens_out(ens_out),
    .core_start(start), .core_run(run),
    .core_pc(pc), .core_ptr(ptr),
    .active_count(cnt), .all_idle(idle),
    .fork_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ens_in = '0;
    cxt = '0;
    halt = '0;
  endtask

  task automatic fk(input int i, input logic v,
                    input logic [15:0] p, input logic [15:0] c);
    ens_in[i] = 1'b1;
    cxt[i*33 +: 33] = {v, p, c};
  endtask

  function automatic logic [15:0] pcof(input int i);
    return pc[i*16 +: 16];
  endfunction

  function automatic logic [15:0] ptrof(input int i);
    return ptr[i*16 +: 16];
  endfunction

  initial begin
    rst_n = 1'b0;
    clr();
    #12;
    chk("rst_ens", 32'(ens_out), 32'h1);
    chk("rst_run", 32'(run), 32'h1);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_pc0", 32'(pcof(0)), 32'(BP));
    chk("rst_ptr0", 32'(ptrof(0)), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h1);
    chk("rst_idle", 32'(idle), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_start", 32'(start), 32'h0);
    chk("post_rst_run", 32'(run), 32'h1);

    // fork core 1
    fk(1, 1'b1, 16'h0040, 16'h0123);
    tick();
    clr();
    chk("f1_start", 32'(start), 32'h2);
    chk("f1_ens", 32'(ens_out), 32'h3);
    chk("f1_run", 32'(run), 32'h1);
    chk("f1_pc", 32'(pcof(1)), 32'h0123);
    chk("f1_ptr", 32'(ptrof(1)), 32'h0040);
    chk("f1_cnt", 32'(cnt), 32'h2);
    tick();
    chk("f1_start_off", 32'(start), 32'h0);
    chk("f1_run1", 32'(run), 32'h3);

    // enable without valid, halt on idle core: ignored
    fk(2, 1'b0, 16'h1111, 16'h2222);
    halt = 4'b0100;
    tick();
    clr();
    chk("nv_ens", 32'(ens_out), 32'h3);
    chk("nv_err", 32'(err), 32'h0);
    chk("nv_pc2", 32'(pcof(2)), 32'h0);

    // halt core 1 at M
    halt = 4'b0010;
    tick();
    clr();
    chk("h1_ens", 32'(ens_out), 32'h3);
    chk("h1_run", 32'(run), 32'h1);
    chk("h1_cnt", 32'(cnt), 32'h2);
    // fork at M+1 while DRAIN: rejected
    fk(1, 1'b1, 16'h0080, 16'h0456);
    tick();
    chk("rej_ens", 32'(ens_out), 32'h1);
    chk("rej_err", 32'(err), 32'h1);
    chk("rej_pc", 32'(pcof(1)), 32'h0123);
    chk("rej_cnt", 32'(cnt), 32'h1);
    // same fork at M+2: accepted
    tick();
    clr();
    chk("acc_start", 32'(start), 32'h2);
    chk("acc_pc", 32'(pcof(1)), 32'h0456);
    chk("acc_ptr", 32'(ptrof(1)), 32'h0080);
    chk("acc_ens", 32'(ens_out), 32'h3);
    tick();
    chk("acc_run", 32'(run), 32'h3);
    chk("err_sticky", 32'(err), 32'h1);

    // forks to 2,3 plus halt on 0 in one edge
    fk(2, 1'b1, 16'h0200, 16'h0222);
    fk(3, 1'b1, 16'h0300, 16'h0333);
    halt = 4'b0001;
    tick();
    clr();
    chk("cc_ens", 32'(ens_out), 32'hF);
    chk("cc_cnt", 32'(cnt), 32'h4);
    chk("cc_start", 32'(start), 32'hC);
    chk("cc_run", 32'(run), 32'h2);
    tick();
    chk("cc_ens2", 32'(ens_out), 32'hE);
    chk("cc_cnt2", 32'(cnt), 32'h3);
    chk("cc_run2", 32'(run), 32'hE);

    // all halt
    halt = 4'b1110;
    tick();
    clr();
    chk("ah_ens", 32'(ens_out), 32'hE);
    chk("ah_run", 32'(run), 32'h0);
    chk("ah_idle", 32'(idle), 32'h0);
    tick();
    chk("ah_ens2", 32'(ens_out), 32'h0);
    chk("ah_cnt", 32'(cnt), 32'h0);
    chk("ah_idle2", 32'(idle), 32'h1);
    chk("ah_pc2", 32'(pcof(2)), 32'h0222);
    chk("ah_ptr3", 32'(ptrof(3)), 32'h0300);
    chk("ah_pc0", 32'(pcof(0)), 32'(BP));

    // build: core1 LOAD, core2 RUN, core3 DRAIN
    fk(2, 1'b1, 16'h0A00, 16'h0AAA);
    tick();
    clr();
    fk(3, 1'b1, 16'h0B00, 16'h0BBB);
    tick();
    clr();
    tick();
    halt = 4'b1000;
    fk(1, 1'b1, 16'h0C00, 16'h0CCC);
    tick();
    clr();
    chk("pre_rst_ens", 32'(ens_out), 32'hE);
    chk("pre_rst_start", 32'(start), 32'h2);
    chk("pre_rst_cnt", 32'(cnt), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("mr_ens", 32'(ens_out), 32'h1);
    chk("mr_start", 32'(start), 32'h0);
    chk("mr_run", 32'(run), 32'h1);
    chk("mr_cnt", 32'(cnt), 32'h1);
    chk("mr_err", 32'(err), 32'h0);
    chk("mr_idle", 32'(idle), 32'h0);
    chk("mr_pc1", 32'(pcof(1)), 32'h0);
    chk("mr_ptr2", 32'(ptrof(2)), 32'h0);
    chk("mr_pc0", 32'(pcof(0)), 32'(BP));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr2_start", 32'(start), 32'h0);
    chk("mr2_ens", 32'(ens_out), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
